// File: rtl/seven_seg_capture_pkg.sv
// ============================================================================
//  Module   : seven_seg_capture_pkg
//  Purpose  : Segment patterns, digit codes and FSM encoding shared by the
//             seven-segment capture path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_capture_pkg;

    // Segment order is {a,b,c,d,e,f,g}; 1 = lit
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_INVALID = 4'hE;
    localparam logic [3:0] CODE_BLANK   = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seven_seg_encode.sv
// ============================================================================
//  Module   : seven_seg_encode
//  Purpose  : Maps a seven-segment pattern back to its 4-bit digit code.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_encode
    import seven_seg_capture_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_invalid
);

    always_comb begin
        o_code    = CODE_INVALID;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:     o_code = 4'h0;
            SEG_1:     o_code = 4'h1;
            SEG_2:     o_code = 4'h2;
            SEG_3:     o_code = 4'h3;
            SEG_4:     o_code = 4'h4;
            SEG_5:     o_code = 4'h5;
            SEG_6:     o_code = 4'h6;
            SEG_7:     o_code = 4'h7;
            SEG_8:     o_code = 4'h8;
            SEG_9:     o_code = 4'h9;
            SEG_A:     o_code = 4'hA;
            SEG_B:     o_code = 4'hB;
            SEG_C:     o_code = 4'hC;
            SEG_BLANK: o_code = CODE_BLANK;
            default: begin
                o_code    = CODE_INVALID;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_capture.sv
// ============================================================================
//  Module   : seven_seg_capture
//  Purpose  : Qualifies a multiplexed seven-segment bus and assembles the
//             decoded digits into a multi-digit frame word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seven_seg,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] digits_BCD,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    sel_err
);

    localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_pc_w  = $clog2(NUM_DIGITS + 1);
    localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYCLES);

    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_sel;
    state_t                  r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [NUM_DIGITS-1:0]   r_flags;

    logic [c_pc_w-1:0]       w_pop;
    logic                    w_one_hot;
    logic                    w_multi;
    logic                    w_same;
    logic [c_cnt_w-1:0]      w_cnt_inc;
    logic                    w_accept;
    logic [c_idx_w-1:0]      w_idx;
    logic [3:0]              w_code;
    logic                    w_invalid;
    logic [4*NUM_DIGITS-1:0] w_merged;
    logic [NUM_DIGITS-1:0]   w_mask_nx;
    logic [NUM_DIGITS-1:0]   w_flags_nx;
    logic                    w_complete;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_pop = w_pop + c_pc_w'(digit_sel[i]);
        end
    end

    assign w_one_hot = (w_pop == c_pc_w'(1));
    assign w_multi   = (w_pop >  c_pc_w'(1));

    // The incoming value is compared with the sample already held, so the
    // edge that registers a new pattern is already its first counted cycle.
    assign w_same    = (seven_seg == r_seg) && (digit_sel == r_sel);
    assign w_cnt_inc = r_cnt + c_cnt_w'(1);
    assign w_accept  = (r_state == SETTLE) && w_one_hot && w_same && (w_cnt_inc == c_stable);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_sel[i]) begin
                w_idx = c_idx_w'(i);
            end
        end
    end

    seven_seg_encode u_encode (
        .i_seg     (r_seg),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    // Slot contents as they will stand after this accept
    always_comb begin
        w_merged = r_shadow;
        w_merged[{w_idx, 2'b00} +: 4] = w_code;
    end

    assign w_mask_nx  = r_mask | r_sel;
    assign w_flags_nx = (r_flags & ~r_sel) | (w_invalid ? r_sel : '0);
    assign w_complete = &w_mask_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg       <= '0;
            r_sel       <= '0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shadow    <= {NUM_DIGITS{CODE_BLANK}};
            r_mask      <= '0;
            r_flags     <= '0;
            digits_BCD  <= {NUM_DIGITS{CODE_BLANK}};
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            r_seg       <= seven_seg;
            r_sel       <= digit_sel;
            sel_err     <= w_multi;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (!w_one_hot) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= SETTLE;
                        r_cnt   <= c_cnt_w'(1);
                    end
                    SETTLE: begin
                        if (!w_same) begin
                            r_cnt <= c_cnt_w'(1);
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_stable) begin
                                r_state <= HELD;
                            end
                        end
                    end
                    HELD: begin
                        if (!w_same) begin
                            r_state <= SETTLE;
                            r_cnt   <= c_cnt_w'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end

            if (w_accept) begin
                r_shadow <= w_merged;
                if (w_complete) begin
                    digits_BCD  <= w_merged;
                    frame_valid <= 1'b1;
                    frame_err   <= |w_flags_nx;
                    r_mask      <= '0;
                    r_flags     <= '0;
                end else begin
                    r_mask  <= w_mask_nx;
                    r_flags <= w_flags_nx;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
// ============================================================================
//  Module   : tb_seven_seg_capture
//  Purpose  : Self-checking bench for seven_seg_capture against a run-length
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_capture;

    localparam int N = 4;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [6:0]   seg = '0;
    logic [N-1:0] sel = '0;
    logic [4*N-1:0] digits_BCD;
    logic         frame_valid;
    logic         frame_err;
    logic         sel_err;

    always #5 clk = ~clk;

    seven_seg_capture #(
        .NUM_DIGITS    (N),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seven_seg   (seg),
        .digit_sel   (sel),
        .digits_BCD  (digits_BCD),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sel_err     (sel_err)
    );

    int pass_cnt    = 0;
    int check_cnt   = 0;
    int frames_seen = 0;
    int selerr_seen = 0;
    logic last_ferr = 1'b0;

    // Digit patterns 0..C in code order
    logic [6:0] tab [13] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110};

    // Reference model: length of the current run of identical one-hot samples
    logic [6:0]   m_last_seg;
    logic [N-1:0] m_last_sel;
    int           m_run;
    logic [3:0]   m_shadow [N];
    logic [N-1:0] m_mask, m_flag;
    logic [4*N-1:0] m_digits;
    logic         m_valid, m_err, m_selerr;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 13; k++) begin
            if (tab[k] == p) return {1'b0, 4'(k)};
        end
        if (p == 7'b0000000) return 5'h0F;
        return 5'h1E;
    endfunction

    task automatic model_reset();
        m_last_seg = '0; m_last_sel = '0; m_run = 0;
        for (int k = 0; k < N; k++) m_shadow[k] = 4'hF;
        m_mask = '0; m_flag = '0; m_digits = '1;
        m_valid = 1'b0; m_err = 1'b0; m_selerr = 1'b0;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic [N-1:0] d);
        logic [4:0] dec;
        int idx;
        m_valid  = 1'b0;
        m_selerr = ($countones(d) >= 2);
        if ($countones(d) != 1)                    m_run = 0;
        else if (s == m_last_seg && d == m_last_sel) m_run++;
        else                                        m_run = 1;
        m_last_seg = s;
        m_last_sel = d;
        if (m_run == S) begin
            idx = 0;
            for (int k = 0; k < N; k++) if (d[k]) idx = k;
            dec = ref_decode(s);
            m_shadow[idx] = dec[3:0];
            m_flag[idx]   = dec[4];
            m_mask[idx]   = 1'b1;
            if (&m_mask) begin
                for (int k = 0; k < N; k++) m_digits[4*k +: 4] = m_shadow[k];
                m_valid = 1'b1;
                m_err   = |m_flag;
                m_mask  = '0;
                m_flag  = '0;
            end
        end
    endtask

    task automatic cycle(input logic [6:0] s, input logic [N-1:0] d);
        seg = s;
        sel = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(s, d);
        #1;
        if (frame_valid === 1'b1) begin
            frames_seen++;
            last_ferr = frame_err;
        end
        if (sel_err === 1'b1) selerr_seen++;
    endtask

    task automatic hold(input logic [6:0] s, input logic [N-1:0] d, input int n);
        repeat (n) cycle(s, d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold(7'b0, '0, 2);
        rst = 1'b0;
        check_cnt++; if (digits_BCD !== 16'hFFFF) $display("FAIL reset digits: got %h want ffff", digits_BCD); else pass_cnt++;
        check_cnt++; if (frame_valid !== 1'b0) $display("FAIL reset frame_valid: got %b want 0", frame_valid); else pass_cnt++;
        check_cnt++; if (frame_err !== 1'b0) $display("FAIL reset frame_err: got %b want 0", frame_err); else pass_cnt++;
        check_cnt++; if (sel_err !== 1'b0) $display("FAIL reset sel_err: got %b want 0", sel_err); else pass_cnt++;
    endtask

    task automatic test_full_frame();
        frames_seen = 0;
        hold(tab[1],  4'b0001, 6);
        hold(tab[2],  4'b0010, 6);
        hold(tab[10], 4'b0100, 6);
        hold(tab[0],  4'b1000, 6);
        hold(7'b0, 4'b0000, 2);
        check_cnt++; if (frames_seen != 1) $display("FAIL full_frame count: got %0d want 1", frames_seen); else pass_cnt++;
        check_cnt++; if (digits_BCD !== 16'h0A21) $display("FAIL full_frame digits: got %h want 0a21", digits_BCD); else pass_cnt++;
        check_cnt++; if (last_ferr !== 1'b0) $display("FAIL full_frame err: got %b want 0", last_ferr); else pass_cnt++;
    endtask

    task automatic test_glitch();
        frames_seen = 0;
        hold(tab[7], 4'b0001, 6);
        hold(tab[3], 4'b0010, 3);
        hold(tab[1], 4'b0010, 5);
        hold(tab[5], 4'b0100, 6);
        hold(tab[9], 4'b1000, 6);
        check_cnt++; if (frames_seen != 1) $display("FAIL glitch count: got %0d want 1", frames_seen); else pass_cnt++;
        check_cnt++; if (digits_BCD !== 16'h9517) $display("FAIL glitch digits: got %h want 9517", digits_BCD); else pass_cnt++;
    endtask

    task automatic test_invalid_blank();
        frames_seen = 0;
        hold(tab[4],     4'b0001, 6);
        hold(tab[8],     4'b0010, 6);
        hold(7'b1010101, 4'b0100, 6);
        hold(7'b0000000, 4'b1000, 6);
        check_cnt++; if (frames_seen != 1) $display("FAIL invalid count: got %0d want 1", frames_seen); else pass_cnt++;
        check_cnt++; if (digits_BCD !== 16'hFE84) $display("FAIL invalid digits: got %h want fe84", digits_BCD); else pass_cnt++;
        check_cnt++; if (last_ferr !== 1'b1) $display("FAIL invalid err: got %b want 1", last_ferr); else pass_cnt++;
    endtask

    task automatic test_sel_err();
        frames_seen = 0;
        selerr_seen = 0;
        hold(tab[2], 4'b0011, 1);
        hold(7'b0, 4'b0000, 1);
        check_cnt++; if (selerr_seen != 1) $display("FAIL sel_err single: got %0d want 1", selerr_seen); else pass_cnt++;
        selerr_seen = 0;
        hold(tab[6], 4'b0101, 6);
        hold(7'b0, 4'b0000, 1);
        check_cnt++; if (selerr_seen != 6) $display("FAIL sel_err held: got %0d want 6", selerr_seen); else pass_cnt++;
        selerr_seen = 0;
        hold(tab[3], 4'b0000, 10);
        check_cnt++; if (selerr_seen != 0) $display("FAIL sel_err idle: got %0d want 0", selerr_seen); else pass_cnt++;
        hold(tab[3], 4'b0010, 6);
        hold(tab[2], 4'b0100, 6);
        hold(tab[1], 4'b1000, 6);
        check_cnt++; if (frames_seen != 0) $display("FAIL sel_err no_accept: got %0d want 0", frames_seen); else pass_cnt++;
        hold(tab[12], 4'b0001, 6);
        check_cnt++; if (frames_seen != 1 || digits_BCD !== 16'h123C)
            $display("FAIL sel_err frame: got %0d/%h want 1/123c", frames_seen, digits_BCD); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        hold(tab[5], 4'b0001, 6);
        hold(tab[6], 4'b0010, 6);
        hold(tab[7], 4'b0100, 6);
        rst = 1'b1;
        cycle(tab[7], 4'b0100);
        rst = 1'b0;
        frames_seen = 0;
        check_cnt++; if (digits_BCD !== 16'hFFFF) $display("FAIL midrst digits: got %h want ffff", digits_BCD); else pass_cnt++;
        hold(tab[12], 4'b1000, 50);
        hold(tab[8],  4'b0001, 6);
        hold(tab[9],  4'b0010, 6);
        hold(tab[11], 4'b0100, 6);
        check_cnt++; if (frames_seen != 1 || digits_BCD !== 16'hCB98)
            $display("FAIL midrst frame: got %0d/%h want 1/cb98", frames_seen, digits_BCD); else pass_cnt++;
        hold(tab[1], 4'b0001, 6);
        hold(tab[2], 4'b0010, 6);
        hold(tab[3], 4'b0100, 6);
        check_cnt++; if (frames_seen != 1) $display("FAIL long_hold reaccept: got %0d want 1", frames_seen); else pass_cnt++;
        hold(tab[4], 4'b1000, 6);
        check_cnt++; if (frames_seen != 2 || digits_BCD !== 16'h4321)
            $display("FAIL long_hold frame: got %0d/%h want 2/4321", frames_seen, digits_BCD); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        frames_seen = 0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < N; p++) begin
                for (int c = 0; c < S; c++) begin
                    cycle(tab[(f * 4 + p + 3) % 13], 4'(1 << p));
                    check_cnt++;
                    if (frame_valid !== m_valid) $display("FAIL b2b frame_valid f%0d p%0d c%0d: got %b want %b", f, p, c, frame_valid, m_valid);
                    else pass_cnt++;
                end
            end
        end
        check_cnt++; if (frames_seen != 2 || digits_BCD !== 16'hA987)
            $display("FAIL b2b frame: got %0d/%h want 2/a987", frames_seen, digits_BCD); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [6:0]   s;
        logic [N-1:0] d;
        int           r, len;
        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      d = 4'(1 << $urandom_range(0, N - 1));
            else if (r < 85) d = '0;
            else             d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 8) s = tab[$urandom_range(0, 12)];
            else                          s = 7'($urandom);
            len = int'($urandom_range(1, 7));
            for (int c = 0; c < len; c++) begin
                cycle(s, d);
                check_cnt++;
                if (frame_valid !== m_valid || sel_err !== m_selerr || digits_BCD !== m_digits ||
                    (m_valid && frame_err !== m_err))
                    $display("FAIL random t%0d: got v%b e%b s%b %h want v%b e%b s%b %h", t,
                             frame_valid, frame_err, sel_err, digits_BCD, m_valid, m_err, m_selerr, m_digits);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_glitch();
        test_invalid_blank();
        test_sel_err();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

`default_nettype wire
